fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register of the 16-bit 5-stage CPU.
- Owns the PC and drives instruction-memory requests (variable-latency memory with a done handshake).
- Produces FD_instr, FD_pc2 and FD_valid for decode. The hazard unit compares FD_instr against the next instruction.
- Consumes `stall` from the hazard unit and `redirect`/`redirect_pc` from branch/jump resolution. Tracks HALT.

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_stage_fd_pipe_reg.sv | 55 +++++
 rtl/fetch_stage.sv | 173 +++++++++++++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the fetch stage of the 16-bit CPU.
// Holds the PC width, the bubble and HALT instruction encodings, the fetch
// state encoding and small PC arithmetic helpers.
package fetch_stage_pkg;

    localparam int PC_WIDTH = 16;

    localparam logic [15:0] NOP_INSTR_C  = 16'h0800;
    localparam logic [15:0] HALT_INSTR_C = 16'h0000;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // Sequential PC step; wraps modulo 2^16 with no flag.
    function automatic logic [PC_WIDTH-1:0] pc_plus2(input logic [PC_WIDTH-1:0] pc);
        return pc + 16'd2;
    endfunction

    // Instructions are halfword aligned, so bit 0 of a target is dropped.
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return {pc[PC_WIDTH-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_stage_fd_pipe_reg.sv
// fd_pipe_reg: IF/ID pipeline register.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   load_i               capture instr_i / pc2_i and mark valid
//   flush_i              write a bubble (NOP, valid=0); wins over load_i
//   instr_i, pc2_i       fetched instruction and its PC+2
//   instr_o, pc2_o       registered instruction / PC+2 for decode
//   valid_o              instr_o holds a real fetched instruction
// With neither load_i nor flush_i asserted the register holds.
module fd_pipe_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                flush_i,
    input  logic [PC_WIDTH-1:0] instr_i,
    input  logic [PC_WIDTH-1:0] pc2_i,
    output logic [PC_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0] pc2_o,
    output logic                valid_o
);

    logic [PC_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0] pc2_q;
    logic                valid_q;

    // IF/ID register: reset, flush to bubble, load, or hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= NOP_INSTR;
            pc2_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            // A bubble keeps the stale pc2; decode ignores it when invalid.
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc2_q   <= pc2_i;
            valid_q <= 1'b1;
        end else begin
            instr_q <= instr_q;
            pc2_q   <= pc2_q;
            valid_q <= valid_q;
        end
    end

    assign instr_o = instr_q;
    assign pc2_o   = pc2_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID register of the 16-bit 5-stage CPU.
// Owns the PC, issues instruction-memory reads (variable latency, done
// handshake) and feeds decode through fd_pipe_reg. Tracks HALT.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall                     hold PC and IF/ID
//   redirect, redirect_pc     taken branch/jump and its target
//   imem_en, imem_addr        read request, address = PC
//   imem_data, imem_done      returned instruction and its valid strobe
//   FD_instr, FD_pc2, FD_valid  IF/ID contents
//   halted                    HALT fetched, fetch stopped
//   err                       sticky misaligned-redirect flag
// Optional feature, macro FETCH_PERF_CTR_EN: adds saturating counters
//   perf_stall_cnt (stall without redirect) and perf_flush_cnt (redirect).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = NOP_INSTR_C,
    parameter logic [15:0] HALT_INSTR = HALT_INSTR_C
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_en,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [PC_WIDTH-1:0] imem_data,
    input  logic                imem_done,
    output logic [PC_WIDTH-1:0] FD_instr,
    output logic [PC_WIDTH-1:0] FD_pc2,
    output logic                FD_valid,
    output logic                halted,
    output logic                err
`ifdef FETCH_PERF_CTR_EN
    ,
    output logic [15:0]         perf_stall_cnt,
    output logic [15:0]         perf_flush_cnt
`endif
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                err_q, err_d;
    logic                fd_load_s;
    logic                fd_flush_s;

    // State register: FSM state, PC and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: redirect > stall > memory done > memory busy.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        err_d      = err_q;
        fd_load_s  = 1'b0;
        fd_flush_s = 1'b0;
        if (redirect) begin
            // Flush dominates hold; any returning data is dropped, which
            // also discards a HALT fetched in the branch shadow.
            state_d    = FETCH;
            pc_d       = align_pc(redirect_pc);
            fd_flush_s = 1'b1;
            if (redirect_pc[0]) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else if (stall) begin
            // Hold everything; the same PC is re-requested next cycle.
            state_d = state_q;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_done) begin
                        fd_load_s = 1'b1;
                        pc_d      = pc_plus2(pc_q);
                        if (imem_data == HALT_INSTR) begin
                            state_d = HALTED;
                        end else begin
                            state_d = FETCH;
                        end
                    end else begin
                        fd_flush_s = 1'b1;
                    end
                end
                HALTED: begin
                    fd_flush_s = 1'b1;
                end
                default: begin
                    state_d    = FETCH;
                    fd_flush_s = 1'b1;
                end
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        imem_en = 1'b0;
        halted  = 1'b0;
        case (state_q)
            FETCH: begin
                imem_en = 1'b1;
                halted  = 1'b0;
            end
            HALTED: begin
                imem_en = 1'b0;
                halted  = 1'b1;
            end
            default: begin
                imem_en = 1'b0;
                halted  = 1'b0;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign err       = err_q;

    fd_pipe_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_fd_pipe_reg (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (fd_load_s),
        .flush_i (fd_flush_s),
        .instr_i (imem_data),
        .pc2_i   (pc_plus2(pc_q)),
        .instr_o (FD_instr),
        .pc2_o   (FD_pc2),
        .valid_o (FD_valid)
    );

`ifdef FETCH_PERF_CTR_EN
    logic [15:0] perf_stall_q;
    logic [15:0] perf_flush_q;

    // Saturating performance counters; a redirect cycle counts as a flush only.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 16'h0000;
            perf_flush_q <= 16'h0000;
        end else begin
            if (redirect && (perf_flush_q != 16'hFFFF)) begin
                perf_flush_q <= perf_flush_q + 16'd1;
            end else begin
                perf_flush_q <= perf_flush_q;
            end
            if (stall && !redirect && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end else begin
                perf_stall_q <= perf_stall_q;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized stimulus for fetch_stage, checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [15:0] NOP  = 16'h0800;
    localparam logic [15:0] HALT = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_done;
    logic [15:0] FD_instr;
    logic [15:0] FD_pc2;
    logic        FD_valid;
    logic        halted;
    logic        err;
`ifdef FETCH_PERF_CTR_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_done   (imem_done),
        .FD_instr    (FD_instr),
        .FD_pc2      (FD_pc2),
        .FD_valid    (FD_valid),
        .halted      (halted),
        .err         (err)
`ifdef FETCH_PERF_CTR_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pc2;
    logic        m_valid;
    logic        m_halt;
    logic        m_err;
    logic [15:0] m_ps;
    logic [15:0] m_pf;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_regs();
        chk("FD_instr", FD_instr, m_instr);
        chk("FD_pc2", FD_pc2, m_pc2);
        chk("FD_valid", {15'd0, FD_valid}, {15'd0, m_valid});
        chk("halted", {15'd0, halted}, {15'd0, m_halt});
        chk("err", {15'd0, err}, {15'd0, m_err});
`ifdef FETCH_PERF_CTR_EN
        chk("perf_stall", perf_stall_cnt, m_ps);
        chk("perf_flush", perf_flush_cnt, m_pf);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        imem_done = 1'b1; imem_data = 16'h1234;
        @(posedge clk);
        m_pc = 16'h0000; m_instr = NOP; m_pc2 = 16'h0000; m_valid = 1'b0;
        m_halt = 1'b0; m_err = 1'b0; m_ps = 16'h0000; m_pf = 16'h0000;
        #1;
        check_regs();
    endtask

    // One clock: drive, check request outputs, clock, advance model, check IF/ID.
    task automatic step(input logic s, input logic r, input logic [15:0] rpc,
                        input logic d, input logic [15:0] data);
        @(negedge clk);
        rst = 1'b0; stall = s; redirect = r; redirect_pc = rpc;
        imem_done = d; imem_data = data;
        #1;
        chk("imem_en", {15'd0, imem_en}, {15'd0, !m_halt});
        if (!m_halt) chk("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        if (r) m_pf = (m_pf == 16'hFFFF) ? m_pf : m_pf + 16'd1;
        else if (s) m_ps = (m_ps == 16'hFFFF) ? m_ps : m_ps + 16'd1;
        if (r) begin
            m_pc = rpc & 16'hFFFE;
            m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0;
            if (rpc[0]) m_err = 1'b1;
        end else if (s) begin
            // everything holds
        end else if (m_halt || !d) begin
            m_instr = NOP; m_valid = 1'b0;
        end else begin
            m_instr = data; m_pc2 = m_pc + 16'd2; m_valid = 1'b1;
            m_pc = m_pc + 16'd2;
            if (data == HALT) m_halt = 1'b1;
        end
        #1;
        check_regs();
    endtask

    initial begin
        do_reset();
        // Sequential fetch from 0.
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4101);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4202);
        // Stall for two cycles, then release.
        step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4303);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4303);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4303);
        // Redirect together with stall.
        step(1'b1, 1'b1, 16'h0040, 1'b1, 16'h5555);
        // Multi-cycle memory: three busy cycles then done.
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h6666);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h6666);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h6666);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444);
        // HALT, NOP cycles, then branch-shadow recovery.
        step(1'b0, 1'b0, 16'h0000, 1'b1, HALT);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
        step(1'b0, 1'b1, 16'h0010, 1'b1, 16'h7777);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4a4a);
        // Redirect + done + HALT data: HALT dropped.
        step(1'b0, 1'b1, 16'hFFFE, 1'b1, HALT);
        // Wrap at 0xFFFE.
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4b4b);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4c4c);
        // Misaligned target: err sticks.
        step(1'b0, 1'b1, 16'h0013, 1'b1, 16'h1111);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4d4d);
        step(1'b0, 1'b1, 16'h0020, 1'b0, 16'h1111);
        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic        s, r, d;
            logic [15:0] rpc, data;
            s    = ($urandom_range(0, 3) == 0);
            r    = ($urandom_range(0, 6) == 0);
            d    = ($urandom_range(0, 9) < 7);
            rpc  = 16'($urandom);
            data = ($urandom_range(0, 9) == 0) ? HALT : 16'($urandom);
            step(s, r, rpc, d, data);
        end
        // Reset clears sticky err and halted.
        step(1'b0, 1'b1, 16'h0101, 1'b1, HALT);
        do_reset();
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4101);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
